// File: rtl/serial_compare_arbiter_if.sv
// Request/serial/result bundle between two requesters, the serial comparator and the
// result consumer.
interface serial_compare_arbiter_if #(
  parameter int unsigned WIDTH = 8
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             ser_a;
  logic             ser_b;
  logic             ser_first;
  logic             res_valid;
  logic             res_ready;
  logic             res_id;
  logic             res_less;
  logic             res_eq;
  logic             res_greater;
  logic             busy;

  modport slave (
    input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, res_ready,
    output req0_ready, req1_ready, ser_a, ser_b, ser_first,
    output res_valid, res_id, res_less, res_eq, res_greater, busy
  );

  modport master (
    output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, res_ready,
    input  req0_ready, req1_ready, ser_a, ser_b, ser_first,
    input  res_valid, res_id, res_less, res_eq, res_greater, busy
  );
endinterface

// File: rtl/serial_compare_arbiter.sv
// Two-requester round-robin arbiter feeding an MSB-first bit-serial magnitude comparator.
// Define SERIAL_CMP_EARLY_EXIT_EN to leave SHIFT right after the first differing bit.
module serial_compare_arbiter #(
  parameter int unsigned WIDTH = 8
) (
  input logic                      clk,
  input logic                      rst,
  serial_compare_arbiter_if.slave  bus
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(WIDTH - 1);

`ifdef SERIAL_CMP_EARLY_EXIT_EN
  localparam bit EarlyExit = 1'b1;
`else
  localparam bit EarlyExit = 1'b0;
`endif

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             id_q, id_d;
  logic             ptr_q, ptr_d;
  logic             lt_q, lt_d, eq_q, eq_d, gt_q, gt_d;

  logic bit_a, bit_b, any_req, gnt_id, differ;

  assign bit_a   = a_q[cnt_q];
  assign bit_b   = b_q[cnt_q];
  assign any_req = bus.req0_valid | bus.req1_valid;
  // Favoured requester wins if valid, otherwise whichever one is asking.
  assign gnt_id  = ptr_q ? bus.req1_valid : ~bus.req0_valid;
  assign differ  = eq_q & (bit_a ^ bit_b);

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    a_d             = a_q;
    b_d             = b_q;
    id_d            = id_q;
    ptr_d           = ptr_q;
    lt_d            = lt_q;
    eq_d            = eq_q;
    gt_d            = gt_q;
    bus.req0_ready  = 1'b0;
    bus.req1_ready  = 1'b0;
    bus.ser_a       = 1'b0;
    bus.ser_b       = 1'b0;
    bus.ser_first   = 1'b0;
    bus.res_valid   = 1'b0;
    bus.res_id      = 1'b0;
    bus.res_less    = 1'b0;
    bus.res_eq      = 1'b0;
    bus.res_greater = 1'b0;
    bus.busy        = (state_q != StIdle);

    unique case (state_q)
      StIdle: begin
        // rst gates the combinational ready so all outputs read 0 during reset.
        if (any_req && !rst) begin
          bus.req0_ready = ~gnt_id;
          bus.req1_ready = gnt_id;
          id_d           = gnt_id;
          a_d            = gnt_id ? bus.req1_a : bus.req0_a;
          b_d            = gnt_id ? bus.req1_b : bus.req0_b;
          cnt_d          = CntMax;
          lt_d           = 1'b0;
          eq_d           = 1'b1;
          gt_d           = 1'b0;
          state_d        = StShift;
        end
      end
      StShift: begin
        bus.ser_a     = bit_a;
        bus.ser_b     = bit_b;
        bus.ser_first = (cnt_q == CntMax);
        if (differ) begin
          eq_d = 1'b0;
          lt_d = bit_b;
          gt_d = bit_a;
        end
        if (cnt_q == '0 || (EarlyExit && differ)) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StDone: begin
        bus.res_valid   = 1'b1;
        bus.res_id      = id_q;
        bus.res_less    = lt_q;
        bus.res_eq      = eq_q;
        bus.res_greater = gt_q;
        if (bus.res_ready) begin
          ptr_d   = ~id_q;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= CntMax;
      a_q     <= '0;
      b_q     <= '0;
      id_q    <= 1'b0;
      ptr_q   <= 1'b0;
      lt_q    <= 1'b0;
      eq_q    <= 1'b1;
      gt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
      lt_q    <= lt_d;
      eq_q    <= eq_d;
      gt_q    <= gt_d;
    end
  end

endmodule

// File: doc/serial_compare_arbiter.md
SERIAL_COMPARE_ARBITER -- requirements
Module: serial_compare_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, the operand width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk  input  1  rising-edge clock.
REQ-003 The block SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 The block SHALL have ports req0_valid / req1_valid  input  1  each, a compare request from requester 0 / 1.
REQ-005 The block SHALL have ports req0_ready / req1_ready  output  1  each, request accepted this cycle.
REQ-006 The block SHALL have ports req0_a, req0_b, req1_a, req1_b  input  WIDTH  each, unsigned operands.
REQ-007 The block SHALL have ports ser_a, ser_b  output  1  each, current serial bit pair, MSB first.
REQ-008 The block SHALL have port ser_first  output  1  high on the first (MSB) bit of each stream.
REQ-009 The block SHALL have ports res_valid  output  1, res_ready  input  1, and res_id  output  1 (requester that owns the result).
REQ-010 The block SHALL have ports res_less, res_eq, res_greater  output  1  each, one-hot result for a versus b.
REQ-011 The block SHALL have port busy  output  1  high whenever the state is not IDLE.

Function
REQ-012 The block SHALL implement FSM states IDLE, SHIFT and DONE.
REQ-013 In IDLE, when at least one reqN_valid is high, the block SHALL grant exactly one requester: the pointer-favoured one if it is valid, otherwise the other.
REQ-014 The grant SHALL assert the granted reqN_ready combinationally in that same IDLE cycle, capture its operands and id, and move to SHIFT.
REQ-015 reqN_ready SHALL be low in SHIFT and DONE and for the non-granted requester.
REQ-016 In SHIFT, each cycle SHALL drive ser_a/ser_b with bit index k of the captured operands, k running from WIDTH-1 down to 0, using a down-counter.
REQ-017 Each SHIFT cycle SHALL update the compare state: while still equal, a=0 and b=1 sets less; a=1 and b=0 sets greater.
REQ-018 Once less or greater is set, it SHALL stay set until the next grant; eq SHALL remain set only if all bits so far matched.
REQ-019 After the k=0 cycle the block SHALL enter DONE, so a grant in cycle T gives res_valid high from cycle T+WIDTH+1.
REQ-020 In DONE, res_valid SHALL be high and res_id/res_less/res_eq/res_greater SHALL hold stable until the cycle in which res_ready is high.
REQ-021 On the res_valid and res_ready handshake, the block SHALL return to IDLE and set the round-robin pointer to the requester not just served.
REQ-022 No new grant SHALL be issued in the handshake cycle; back-to-back operations therefore take WIDTH+2 cycles minimum.
REQ-023 ser_a, ser_b and ser_first SHALL be 0 outside SHIFT.
REQ-024 Exactly one of res_less/res_eq/res_greater SHALL be high while res_valid is high; all three SHALL be 0 otherwise.
REQ-025 When both requesters are valid in the same IDLE cycle, the pointer SHALL decide; a persistent requester SHALL be served within two operations.

Reset
REQ-026 rst high SHALL, asynchronously, force state IDLE, pointer to requester 0, counter to WIDTH-1 and the compare state to eq.
REQ-027 During reset all outputs SHALL be 0, including res_* and busy.
REQ-028 Reset asserted in SHIFT or DONE SHALL discard the operation in progress; no res_valid SHALL follow for it.

Configuration
REQ-029 Macro SERIAL_CMP_EARLY_EXIT_EN SHALL select the exit behaviour below.
REQ-030 With SERIAL_CMP_EARLY_EXIT_EN defined, SHIFT SHALL exit to DONE immediately after the first differing bit, giving res_valid at T+(WIDTH-k)+1 for first difference at index k.
REQ-031 With SERIAL_CMP_EARLY_EXIT_EN defined, equal operands SHALL still take the full WIDTH cycles.
REQ-032 Without SERIAL_CMP_EARLY_EXIT_EN, SHIFT SHALL always run all WIDTH cycles.

Verification
REQ-033 The bench SHALL check, with WIDTH=8 and only req0 holding a=0x5A, b=0x5A, res_ready=1: req0_ready in cycle T, res_valid at T+9, res_eq=1, res_id=0.
REQ-034 The bench SHALL check req1 with a=0x80, b=0x7F: res_greater=1, and ser_first high with ser_a=1, ser_b=0 at T+1.
REQ-035 The bench SHALL check both requesters valid continuously, with req0 a=0x01/b=0x02 and req1 a=0x03/b=0x03: grants alternate 0,1,0,1 and results alternate less, eq.
REQ-036 The bench SHALL check res_ready held low for 5 cycles in DONE: res_* stable, no new req ready; release gives IDLE and a grant one cycle later.
REQ-037 The bench SHALL check rst pulsed at T+4 of an operation: outputs 0 immediately, no res_valid for it, and the next grant goes to req0.
REQ-038 The bench SHALL check, with SERIAL_CMP_EARLY_EXIT_EN defined and a=0x40, b=0x00: res_valid at T+3 with res_greater=1; without the macro, res_valid at T+9.
